// File: rtl/btn_debounce_pulse_pkg.sv
// btn_debounce_pulse_pkg: debounce FSM state encodings and board-clock defaults
package btn_debounce_pulse_pkg;
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_CNT_W         = 16;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: multi-flop synchroniser for an asynchronous input with sync clear to a fixed level
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk)
    ff <= !clr_n ? {STAGES{RST_VAL}} : {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronise and debounce a push-button into a level plus press/release pulses
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int   CNT_W         = DEF_CNT_W,
  parameter logic ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);
  logic             q, s, done;
  state_t           st, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(ACTIVE_LOW)) u_sync (
    .clk(clk), .clr_n(clr_n), .d(btn_raw), .q(q)
  );
  assign s    = q ^ ACTIVE_LOW;
  assign done = cnt == CNT_W'(STABLE_CYCLES - 2);
  always_comb begin
    nxt     = st;
    cnt_nxt = '0;
    case (st)
      IDLE:         nxt = s ? PRESS_WAIT : IDLE;
      PRESS_WAIT: begin
        nxt     = !s ? IDLE : done ? PRESSED : PRESS_WAIT;
        cnt_nxt = (s && !done) ? cnt + 1'b1 : '0;
      end
      PRESSED:      nxt = s ? PRESSED : RELEASE_WAIT;
      RELEASE_WAIT: begin
        nxt     = s ? PRESSED : done ? IDLE : RELEASE_WAIT;
        cnt_nxt = (!s && !done) ? cnt + 1'b1 : '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      st          <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      st          <= nxt;
      cnt         <= cnt_nxt;
      btn_level   <= nxt == PRESSED || nxt == RELEASE_WAIT;
      btn_press   <= st == PRESS_WAIT && nxt == PRESSED;
      btn_release <= st == RELEASE_WAIT && nxt == IDLE;
    end
  end
endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb_btn_debounce_pulse: directed and random checks of two debouncers (index = ACTIVE_LOW) against a run-length model
module tb_btn_debounce_pulse;
  localparam int SS = 2, SC = 4, CW = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] clr_n = 2'b00, raw = 2'b00;
  logic [1:0] lvl, prs, rel;
  int n_cmp = 0, n_bad = 0;

  btn_debounce_pulse #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .CNT_W(CW), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .clr_n(clr_n[0]), .btn_raw(raw[0]),
    .btn_level(lvl[0]), .btn_press(prs[0]), .btn_release(rel[0])
  );
  btn_debounce_pulse #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .CNT_W(CW), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .clr_n(clr_n[1]), .btn_raw(raw[1]),
    .btn_level(lvl[1]), .btn_press(prs[1]), .btn_release(rel[1])
  );

  // Model: raw delayed SS edges, then a level flips once SC consecutive samples disagree with it.
  logic m_sync [2][SS];
  logic m_lvl [2], m_prs [2], m_rel [2];
  int   m_run [2];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic s;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!clr_n[d]) begin
        for (int i = 0; i < SS; i++) m_sync[d][i] = (d == 1);
        m_lvl[d] = 1'b0; m_prs[d] = 1'b0; m_rel[d] = 1'b0; m_run[d] = 0;
      end else begin
        s = m_sync[d][SS-1] ^ (d == 1);
        for (int i = SS - 1; i > 0; i--) m_sync[d][i] = m_sync[d][i-1];
        m_sync[d][0] = raw[d];
        m_prs[d] = 1'b0; m_rel[d] = 1'b0;
        if (s != m_lvl[d]) begin
          m_run[d]++;
          if (m_run[d] == SC) begin
            m_lvl[d] = s; m_run[d] = 0; m_prs[d] = s; m_rel[d] = !s;
          end
        end else m_run[d] = 0;
      end
      chk($sformatf("level[%0d]", d), int'(lvl[d]), int'(m_lvl[d]));
      chk($sformatf("press[%0d]", d), int'(prs[d]), int'(m_prs[d]));
      chk($sformatf("release[%0d]", d), int'(rel[d]), int'(m_rel[d]));
      chk($sformatf("exclusive[%0d]", d), int'(prs[d] & rel[d]), 0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic edges_to_press(input int d, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit && n < 0; i++) begin
      tick();
      if (prs[d]) n = i;
    end
  endtask

  int n, cnt;

  initial begin
    // reset with AL=1 button pressed, AL=0 button released
    raw = 2'b00; clr_n = 2'b00;
    ticks(3);
    chk("reset_level", int'(lvl[1]), 0);
    chk("reset_press", int'(prs[1]), 0);
    chk("reset_release", int'(rel[1]), 0);
    raw[1] = 1'b1; clr_n = 2'b11;
    ticks(10);
    // clean press
    raw[1] = 1'b0;
    ticks(5);
    chk("press_early", int'(prs[1]), 0);
    tick();
    chk("press_edge6", int'(prs[1]), 1);
    chk("level_edge6", int'(lvl[1]), 1);
    tick();
    chk("press_edge7", int'(prs[1]), 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin tick(); cnt += int'(prs[1]); end
    chk("held_no_repeat", cnt, 0);
    // release
    raw[1] = 1'b1;
    ticks(5);
    chk("release_early", int'(rel[1]), 0);
    chk("level_still_high", int'(lvl[1]), 1);
    tick();
    chk("release_edge6", int'(rel[1]), 1);
    chk("level_low_edge6", int'(lvl[1]), 0);
    chk("no_press_on_release", int'(prs[1]), 0);
    tick();
    chk("release_edge7", int'(rel[1]), 0);
    ticks(5);
    // bounce reject
    cnt = 0;
    raw[1] = 1'b0; tick(); cnt += int'(prs[1]); tick(); cnt += int'(prs[1]);
    raw[1] = 1'b1; tick(); cnt += int'(prs[1]);
    raw[1] = 1'b0; tick(); cnt += int'(prs[1]); tick(); cnt += int'(prs[1]);
    raw[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); cnt += int'(prs[1] | lvl[1]); end
    chk("bounce_reject", cnt, 0);
    // bounce then accept
    raw[1] = 1'b0; ticks(2);
    raw[1] = 1'b1; tick();
    raw[1] = 1'b0;
    edges_to_press(1, 20, n);
    chk("bounce_accept_latency", n, 6);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); cnt += int'(prs[1]); end
    chk("bounce_accept_single", cnt, 0);
    raw[1] = 1'b1; ticks(10);
    // reset mid-press on AL=0 instance
    raw[0] = 1'b1;
    ticks(4);
    clr_n[0] = 1'b0;
    ticks(2);
    chk("midreset_no_pulse", int'(prs[0]), 0);
    clr_n[0] = 1'b1;
    edges_to_press(0, 20, n);
    chk("midreset_latency", n, 6);
    raw[0] = 1'b0; ticks(10);
    // random bouncing on both instances with occasional resets
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) raw[d] = 1'($urandom_range(0, 1));
      clr_n[0] = ($urandom_range(0, 30) != 0);
      clr_n[1] = ($urandom_range(0, 30) != 0);
      ticks($urandom_range(1, 8));
    end
    clr_n = 2'b11;
    ticks(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
